// File: rtl/cmp_pkg.sv
// Shared types and constants for the sequential magnitude comparator.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    // Result encodings, ordered {greater, lesser, equal}
    localparam logic [2:0] RES_GT = 3'b100;
    localparam logic [2:0] RES_LT = 3'b010;
    localparam logic [2:0] RES_EQ = 3'b001;

    function automatic int unsigned chunk_count(input int unsigned width,
                                                input int unsigned chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/chunk_cmp.sv
// Unsigned comparison of one CHUNK-bit slice of each operand.
module chunk_cmp #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    output logic             gt,
    output logic             lt
);

    assign gt = (x > y);
    assign lt = (x < y);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: walks the operands CHUNK bits per cycle
// from the MSB end and stops at the first differing chunk.
module seq_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4,
    localparam int unsigned NCHUNK = chunk_count(WIDTH, CHUNK),
    localparam int unsigned IDXW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic            signed_mode,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            greater,
    output logic            lesser,
    output logic            equal,
    output logic [IDXW-1:0] diff_chunk
);

    // Flipping the sign bit maps two's complement order onto unsigned order
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [IDXW-1:0]  diff_q, diff_d;
    logic [2:0]       res_q, res_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic             chunk_gt;
    logic             chunk_lt;

    // Select the chunk currently under comparison
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < int'(NCHUNK); i++) begin
            if (idx_q == IDXW'(i)) begin
                a_chunk = a_q[i*CHUNK +: CHUNK];
                b_chunk = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    chunk_cmp #(
        .CHUNK(CHUNK)
    ) u_chunk_cmp (
        .x (a_chunk),
        .y (b_chunk),
        .gt(chunk_gt),
        .lt(chunk_lt)
    );

    // Next-state logic for the FSM, operands, index and result
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        idx_d       = idx_q;
        diff_d      = diff_q;
        res_d       = res_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d        = a ^ (signed_mode ? MSB_MASK : '0);
                    b_d        = b ^ (signed_mode ? MSB_MASK : '0);
                    idx_d      = IDXW'(NCHUNK - 1);
                    in_ready_d = 1'b0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                if (chunk_gt || chunk_lt) begin
                    res_d       = chunk_gt ? RES_GT : RES_LT;
                    diff_d      = idx_q;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else if (idx_q == '0) begin
                    res_d       = RES_EQ;
                    diff_d      = '0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    idx_d = idx_q - IDXW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset discards any pending result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            idx_q       <= '0;
            diff_q      <= '0;
            res_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            idx_q       <= idx_d;
            diff_q      <= diff_d;
            res_q       <= res_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign greater    = res_q[2];
    assign lesser     = res_q[1];
    assign equal      = res_q[0];
    assign diff_chunk = diff_q;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Directed and randomised checks of seq_magnitude_comparator at CHUNK=4, 16 and 1.
module tb_seq_magnitude_comparator;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [15:0] b;
    logic        sm;

    // CHUNK=4 instance
    logic       iv, ir, ov, ordy, gt, lt, eq;
    logic [1:0] diff;
    // CHUNK=16 instance
    logic       iv16, ir16, ov16, ordy16, gt16, lt16, eq16;
    logic [0:0] diff16;
    // CHUNK=1 instance
    logic       iv1, ir1, ov1, ordy1, gt1, lt1, eq1;
    logic [3:0] diff1;

    int n_checks = 0;
    int n_fail   = 0;

    seq_magnitude_comparator #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .a(a), .b(b),
        .signed_mode(sm), .out_valid(ov), .out_ready(ordy), .greater(gt),
        .lesser(lt), .equal(eq), .diff_chunk(diff)
    );

    seq_magnitude_comparator #(.WIDTH(16), .CHUNK(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a), .b(b),
        .signed_mode(sm), .out_valid(ov16), .out_ready(ordy16), .greater(gt16),
        .lesser(lt16), .equal(eq16), .diff_chunk(diff16)
    );

    seq_magnitude_comparator #(.WIDTH(16), .CHUNK(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a), .b(b),
        .signed_mode(sm), .out_valid(ov1), .out_ready(ordy1), .greater(gt1),
        .lesser(lt1), .equal(eq1), .diff_chunk(diff1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one operation on the CHUNK=4 instance and wait for its result
    task automatic do_op(input logic [15:0] ta, input logic [15:0] tbv, input logic tsm,
                         output logic [2:0] r, output logic [1:0] d, output int lat);
        a = ta; b = tbv; sm = tsm; iv = 1'b1;
        @(posedge clk); #1;
        iv = 1'b0;
        lat = 0;
        while (!ov && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!ov) lat = 99;
        r = {gt, lt, eq};
        d = diff;
    endtask

    task automatic pop();
        ordy = 1'b1;
        @(posedge clk); #1;
        ordy = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #23;
        n_checks++;
        if ({ir, ov, gt, lt, eq, diff} !== 7'b1000000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 1000000", {ir, ov, gt, lt, eq, diff});
        end
        n_checks++;
        if ({ir16, ov16, ir1, ov1, diff1} !== 8'b10100000) begin
            n_fail++;
            $display("FAIL reset_other: got %b expected 10100000",
                     {ir16, ov16, ir1, ov1, diff1});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Directed vectors: a, b, signed_mode, {gt,lt,eq}, diff_chunk, latency
    logic [15:0] va [7] = '{16'hA000, 16'h1234, 16'h12F4, 16'hFFFF, 16'hFFFF, 16'h8000, 16'h1234};
    logic [15:0] vb [7] = '{16'h5000, 16'h1234, 16'h12F5, 16'h0001, 16'h0001, 16'h7FFF, 16'h1334};
    logic        vs [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [2:0]  vr [7] = '{3'b100, 3'b001, 3'b010, 3'b010, 3'b100, 3'b010, 3'b010};
    logic [1:0]  vd [7] = '{2'd3, 2'd0, 2'd0, 2'd3, 2'd3, 2'd3, 2'd2};
    int          vl [7] = '{1, 4, 4, 1, 1, 1, 2};

    task automatic test_directed();
        logic [2:0] r;
        logic [1:0] d;
        int         lat;
        for (int i = 0; i < 7; i++) begin
            do_op(va[i], vb[i], vs[i], r, d, lat);
            n_checks++;
            if (r !== vr[i]) begin
                n_fail++;
                $display("FAIL directed_result[%0d]: got %b expected %b", i, r, vr[i]);
            end
            n_checks++;
            if (d !== vd[i]) begin
                n_fail++;
                $display("FAIL directed_diff[%0d]: got %0d expected %0d", i, d, vd[i]);
            end
            n_checks++;
            if (lat != vl[i]) begin
                n_fail++;
                $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, vl[i]);
            end
            pop();
            n_checks++;
            if ({ir, ov, gt, lt, eq} !== {2'b10, vr[i]}) begin
                n_fail++;
                $display("FAIL directed_release[%0d]: got %b expected %b", i,
                         {ir, ov, gt, lt, eq}, {2'b10, vr[i]});
            end
        end
    endtask

    task automatic test_backpressure();
        logic [2:0] r;
        logic [1:0] d;
        int         lat;
        do_op(16'hA000, 16'h5000, 1'b0, r, d, lat);
        // New operands offered while the result is stalled
        a = 16'h0001; b = 16'h0002; sm = 1'b0; iv = 1'b1; ordy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({ov, ir, gt, lt, eq, diff} !== 7'b1010011) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got %b expected 1010011", i,
                         {ov, ir, gt, lt, eq, diff});
            end
        end
        ordy = 1'b1;
        @(posedge clk); #1;
        ordy = 1'b0;
        n_checks++;
        if ({ov, ir, gt, lt, eq} !== 5'b01100) begin
            n_fail++;
            $display("FAIL stall_release: got %b expected 01100", {ov, ir, gt, lt, eq});
        end
        @(posedge clk); #1;
        iv = 1'b0;
        n_checks++;
        if (ir !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_accept: in_ready got %b expected 0", ir);
        end
        lat = 0;
        while (!ov && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        n_checks++;
        if ({ov, gt, lt, eq, diff} !== 6'b101000 || lat != 4) begin
            n_fail++;
            $display("FAIL stall_next_op: got %b lat %0d expected 101000 lat 4",
                     {ov, gt, lt, eq, diff}, lat);
        end
        pop();
    endtask

    task automatic test_reset_mid_busy();
        logic [2:0] r;
        logic [1:0] d;
        int         lat;
        a = 16'h1234; b = 16'h1234; sm = 1'b0; iv = 1'b1;
        @(posedge clk); #1;
        iv = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ov, ir, gt, lt, eq, diff} !== 7'b0100000) begin
            n_fail++;
            $display("FAIL midbusy_reset: got %b expected 0100000", {ov, ir, gt, lt, eq, diff});
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_checks++;
        if ({ov, ir} !== 2'b01) begin
            n_fail++;
            $display("FAIL midbusy_discard: got %b expected 01", {ov, ir});
        end
        do_op(16'h0F00, 16'h0E00, 1'b0, r, d, lat);
        n_checks++;
        if (r !== 3'b100 || d !== 2'd2 || lat != 2) begin
            n_fail++;
            $display("FAIL midbusy_next_op: got %b d %0d lat %0d expected 100 d 2 lat 2",
                     r, d, lat);
        end
        pop();
    endtask

    task automatic test_sweep();
        logic [15:0] ta, tbv, x;
        logic        tsm, got1, got16;
        logic [2:0]  er, r1, r16;
        logic [3:0]  ed, d1;
        logic [0:0]  d16;
        int          l1, l16, cyc, el;
        for (int i = 0; i < 1000; i++) begin
            ta  = 16'($urandom);
            tbv = 16'($urandom);
            if (i % 4 == 0) tbv = ta;
            else if (i % 4 == 1) tbv = ta ^ (16'h1 << $urandom_range(15, 0));
            tsm = 1'($urandom_range(1, 0));
            if (tsm) er = ($signed(ta) > $signed(tbv)) ? 3'b100 :
                          ($signed(ta) < $signed(tbv)) ? 3'b010 : 3'b001;
            else     er = (ta > tbv) ? 3'b100 : (ta < tbv) ? 3'b010 : 3'b001;
            x  = ta ^ tbv;
            ed = 4'd0;
            for (int j = 0; j < 16; j++) if (x[j]) ed = 4'(j);
            el = 16 - int'(ed);

            a = ta; b = tbv; sm = tsm; iv1 = 1'b1; iv16 = 1'b1;
            @(posedge clk); #1;
            iv1 = 1'b0; iv16 = 1'b0;
            cyc = 0; got1 = 1'b0; got16 = 1'b0; l1 = 99; l16 = 99;
            r1 = '0; r16 = '0; d1 = '0; d16 = '0;
            while (!(got1 && got16) && cyc < 40) begin
                @(posedge clk); #1;
                cyc++;
                if (ov16 && !got16) begin
                    got16 = 1'b1; l16 = cyc; r16 = {gt16, lt16, eq16}; d16 = diff16;
                end
                if (ov1 && !got1) begin
                    got1 = 1'b1; l1 = cyc; r1 = {gt1, lt1, eq1}; d1 = diff1;
                end
            end
            n_checks++;
            if (r16 !== er || d16 !== 1'b0 || l16 != 1) begin
                n_fail++;
                $display("FAIL sweep16[%0d] a=%h b=%h s=%b: got %b d %0d lat %0d expected %b d 0 lat 1",
                         i, ta, tbv, tsm, r16, d16, l16, er);
            end
            n_checks++;
            if (r1 !== er) begin
                n_fail++;
                $display("FAIL sweep1_result[%0d] a=%h b=%h s=%b: got %b expected %b",
                         i, ta, tbv, tsm, r1, er);
            end
            n_checks++;
            if (d1 !== ed || l1 != el) begin
                n_fail++;
                $display("FAIL sweep1_diff_lat[%0d] a=%h b=%h: got d %0d lat %0d expected d %0d lat %0d",
                         i, ta, tbv, d1, l1, ed, el);
            end
            ordy1 = 1'b1; ordy16 = 1'b1;
            @(posedge clk); #1;
            ordy1 = 1'b0; ordy16 = 1'b0;
        end
    endtask

    initial begin
        a = '0; b = '0; sm = 1'b0;
        iv = 1'b0; ordy = 1'b0;
        iv16 = 1'b0; ordy16 = 1'b0;
        iv1 = 1'b0; ordy1 = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_busy();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
